wam_round: RTL and testbench
============================

Name: wam_round

Overview:
- Game-round controller/scheduler for the whack-a-mole datapath.
- Sequences idle, countdown, play and game-over phases.
- Gates the mole generator and score counter, and tracks hits to raise a difficulty level.
- Drives generator configuration (mole lifetime, spawn period) and a seconds countdown for the digit display. Sits between the top-level clock divider/hit logic and wam_gen/wam_swc/wam_dis.

Parameters:
- TICK_DIV, 16: tick strobes per game second (tick is the slow enable, e.g. one clk_19-derived pulse).
- COUNTDOWN_SEC, 3: seconds in READY before play starts.
- ROUND_SEC, 30: seconds of play per round, 1..99.
- LVL_STEP, 10: hits needed per level increase; must be >= 8.
- MAX_LVL, 7: level ceiling, 0..7.
- LIFE_BASE, 12: mole lifetime in ticks at level 0; must be > MAX_LVL.
- SPAWN_BASE, 20: spawn period in ticks at level 0; must be > 2*MAX_LVL.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- tick  in  1  one-clk-wide slow enable strobe.
- start  in  1  raw start button level; edge-detected internally.
- hit  in  8  per-hole hit pulses, one clk wide, any combination.
- state  out  2  0 IDLE, 1 READY, 2 PLAY, 3 OVER.
- gen_en  out  1  mole generator enable.
- hit_en  out  1  score counter enable.
- time_left  out  7  seconds remaining in the current phase.
- level  out  3  current difficulty.
- mole_life  out  4  LIFE_BASE - level.
- spawn_period  out  5  SPAWN_BASE - 2*level.
- hit_total  out  8  hits this round, saturating at 255.
- round_done  out  1  one-clk pulse on PLAY->OVER.

Behaviour:
- Reset (clr high, asynchronous): all of the following are cleared immediately and held while clr=1.
  - state=IDLE, time_left=0, level=0, hit_total=0, round_done=0, gen_en=0, hit_en=0.
  - Level accumulator, second prescaler and start edge register cleared.
  - Consequently mole_life=LIFE_BASE and spawn_period=SPAWN_BASE.
- Start edge:
  - start_q registers start each clk.
  - start_evt = start & ~start_q.
  - Honoured only in IDLE and OVER; ignored in READY and PLAY.
- Second strobe:
  - Prescaler counts tick pulses 0..TICK_DIV-1.
  - sec_stb = tick & (prescaler==TICK_DIV-1).
  - Prescaler resets to 0 on entry to READY and PLAY, so every phase second is exactly TICK_DIV ticks.
- IDLE:
  - Outputs idle.
  - start_evt -> READY next clk; time_left=COUNTDOWN_SEC; level, hit_total and accumulator cleared.
- READY:
  - sec_stb decrements time_left.
  - A sec_stb while time_left==1 -> PLAY; time_left=ROUND_SEC.
  - gen_en=0, hit_en=0.
- PLAY:
  - gen_en=1, hit_en=1 (both combinational from state).
  - Each clk, n = popcount(hit), 0..8.
  - hit_total += n, saturating at 255.
  - acc += n; if the new acc >= LVL_STEP: acc -= LVL_STEP and level++, saturating at MAX_LVL. At most one level step per clk.
  - After level reaches MAX_LVL, acc keeps wrapping but level holds.
  - sec_stb decrements time_left.
  - A sec_stb while time_left==1 -> OVER: time_left=0, round_done=1 for exactly that clk.
  - Hits in the expiry clk are still counted.
- OVER:
  - gen_en=0, hit_en=0.
  - hit_total and level hold for display.
  - start_evt -> READY, same as from IDLE.
- mole_life and spawn_period are combinational from level, registered into the generator domain by wam_gen.
- Hits outside PLAY are ignored entirely.
- A tick with no sec_stb changes only the prescaler.

Optional Feature:
- Macro WAM_ROUND_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit, level) and state encoding PAUSE, with state widened to 3 bits and PAUSE=4.
  - PLAY with pause=1 -> PAUSE next clk.
  - In PAUSE: prescaler, time_left and the level/hit counters are frozen; gen_en=0, hit_en=0; hits are ignored.
  - pause=0 -> PLAY with the prescaler value preserved.
  - clr still forces IDLE.
- When undefined:
  - No pause port; state stays 2 bits; PAUSE is unreachable and absent.

Test Plan (TICK_DIV=4, COUNTDOWN_SEC=3, ROUND_SEC=5, LVL_STEP=10):
- Reset then start pulse -> state=1, time_left=3; after 12 ticks state=2, time_left=5, gen_en=1.
- In PLAY, 5 clks each with hit=8'hFF -> hit_total=40, level=4, mole_life=8, spawn_period=12.
- In PLAY, hit=8'h03 together with the final sec_stb (time_left=1) -> hit_total +2, state=3, round_done high for exactly one clk, time_left=0.
- In READY, start toggled, and hit=8'hFF asserted while in READY -> start ignored, hit_total stays 0, state stays 1.
- 40 clks of hit=8'hFF in PLAY -> hit_total=255 (saturated), level=7, mole_life=5.
- Mid-PLAY clr pulse asynchronous to clk -> state=0, level=0, gen_en=0 immediately; a following start restarts the countdown at time_left=3.

Source files
------------

// File: rtl/wam_round_if.sv
// wam_round_if: control/status bundle between the round controller and its environment.
//   master: drives tick, start, hit (and pause when WAM_ROUND_PAUSE_EN); observes status.
//   slave : the controller; receives inputs, drives state, gen_en, hit_en, time_left,
//           level, mole_life, spawn_period, hit_total, round_done.
//   WAM_ROUND_PAUSE_EN widens state to 3 bits and adds the pause level input.
interface wam_round_if;
    logic       tick;
    logic       start;
    logic [7:0] hit;
`ifdef WAM_ROUND_PAUSE_EN
    logic       pause;
    logic [2:0] state;
`else
    logic [1:0] state;
`endif
    logic       gen_en;
    logic       hit_en;
    logic [6:0] time_left;
    logic [2:0] level;
    logic [3:0] mole_life;
    logic [4:0] spawn_period;
    logic [7:0] hit_total;
    logic       round_done;
`ifdef WAM_ROUND_PAUSE_EN
    modport master (output tick, start, hit, pause,
                    input state, gen_en, hit_en, time_left, level, mole_life, spawn_period, hit_total, round_done);
    modport slave  (input tick, start, hit, pause,
                    output state, gen_en, hit_en, time_left, level, mole_life, spawn_period, hit_total, round_done);
`else
    modport master (output tick, start, hit,
                    input state, gen_en, hit_en, time_left, level, mole_life, spawn_period, hit_total, round_done);
    modport slave  (input tick, start, hit,
                    output state, gen_en, hit_en, time_left, level, mole_life, spawn_period, hit_total, round_done);
`endif
endinterface

// File: rtl/wam_round.sv
// wam_round: whack-a-mole round scheduler (IDLE -> READY countdown -> PLAY -> OVER).
//   clk : system clock
//   clr : asynchronous active-high reset
//   bus : wam_round_if.slave (tick, start, hit[, pause] in; state, gen_en, hit_en,
//         time_left, level, mole_life, spawn_period, hit_total, round_done out)
//   Optional: define WAM_ROUND_PAUSE_EN to add the PAUSE state (encoding 4) and pause input.
module wam_round #(
    parameter int TICK_DIV      = 16,
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 30,
    parameter int LVL_STEP      = 10,
    parameter int MAX_LVL       = 7,
    parameter int LIFE_BASE     = 12,
    parameter int SPAWN_BASE    = 20
) (
    input logic        clk,
    input logic        clr,
    wam_round_if.slave bus
);
`ifdef WAM_ROUND_PAUSE_EN
    typedef enum logic [2:0] {IDLE = 3'd0, READY = 3'd1, PLAY = 3'd2, OVER = 3'd3, PAUSE = 3'd4} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
`endif
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    state_t        st;
    logic          start_q;
    logic [PW-1:0] presc;
    logic [7:0]    acc;
    logic [6:0]    time_left;
    logic [2:0]    level;
    logic [7:0]    hit_total;
    logic          round_done;
    logic [3:0]    n;
    logic [8:0]    tot;
    logic [7:0]    acc_sum;
    logic          start_evt;
    logic          sec_stb;

    always_comb begin
        n         = 4'($countones(bus.hit));
        tot       = {1'b0, hit_total} + {5'b0, n};
        acc_sum   = acc + {4'b0, n};
        start_evt = bus.start & ~start_q;
        sec_stb   = bus.tick & (presc == PW'(TICK_DIV - 1));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st         <= IDLE;
            start_q    <= 1'b0;
            presc      <= '0;
            acc        <= '0;
            time_left  <= '0;
            level      <= '0;
            hit_total  <= '0;
            round_done <= 1'b0;
        end else begin
            start_q    <= bus.start;
            round_done <= 1'b0;
            if (bus.tick)
                presc <= sec_stb ? '0 : presc + 1'b1;
            case (st)
                IDLE, OVER: if (start_evt) begin
                    st        <= READY;
                    time_left <= 7'(COUNTDOWN_SEC);
                    level     <= '0;
                    hit_total <= '0;
                    acc       <= '0;
                    presc     <= '0;
                end
                READY: if (sec_stb) begin
                    // sec_stb already wraps the prescaler, so PLAY starts on a fresh second
                    st        <= time_left == 7'd1 ? PLAY : READY;
                    time_left <= time_left == 7'd1 ? 7'(ROUND_SEC) : time_left - 7'd1;
                end
                PLAY: begin
                    hit_total <= tot[8] ? 8'hFF : tot[7:0];
                    // n <= 8 < LVL_STEP, so one subtraction always brings acc back in range
                    acc       <= acc_sum >= 8'(LVL_STEP) ? acc_sum - 8'(LVL_STEP) : acc_sum;
                    if (acc_sum >= 8'(LVL_STEP) && level != 3'(MAX_LVL))
                        level <= level + 3'd1;
`ifdef WAM_ROUND_PAUSE_EN
                    if (bus.pause)
                        st <= PAUSE;
`endif
                    if (sec_stb) begin
                        time_left <= time_left - 7'd1;
                        if (time_left == 7'd1) begin
                            st         <= OVER;
                            round_done <= 1'b1;
                        end
                    end
                end
`ifdef WAM_ROUND_PAUSE_EN
                PAUSE: begin
                    presc <= presc;
                    if (!bus.pause)
                        st <= PLAY;
                end
`endif
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.state        = st;
    assign bus.gen_en       = st == PLAY;
    assign bus.hit_en       = st == PLAY;
    assign bus.time_left    = time_left;
    assign bus.level        = level;
    assign bus.mole_life    = 4'(LIFE_BASE) - {1'b0, level};
    assign bus.spawn_period = 5'(SPAWN_BASE) - {1'b0, level, 1'b0};
    assign bus.hit_total    = hit_total;
    assign bus.round_done   = round_done;
endmodule

// File: tb/tb_wam_round.sv
// tb_wam_round: self-checking bench for wam_round (vector table, corner sequences, random vs model).
module tb_wam_round;
    localparam int TD = 4, CD = 3, RS = 5, LS = 10, ML = 7, LB = 12, SB = 20;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    wam_round_if bus ();

    wam_round #(
        .TICK_DIV(TD), .COUNTDOWN_SEC(CD), .ROUND_SEC(RS), .LVL_STEP(LS),
        .MAX_LVL(ML), .LIFE_BASE(LB), .SPAWN_BASE(SB)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference: phase progress is expressed as ticks elapsed in the phase,
    // level as whole LVL_STEP multiples of all hits scored this round
    int m_st, m_tl, m_raw, m_ptick;
    bit m_sq, m_rd;

    task automatic model_reset();
        m_st = 0; m_tl = 0; m_raw = 0; m_ptick = 0; m_sq = 0; m_rd = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input logic [7:0] h);
        bit evt;
        evt  = s && !m_sq;
        m_sq = s;
        m_rd = 0;
        if ((m_st == 0 || m_st == 3) && evt) begin
            m_st = 1; m_tl = CD; m_raw = 0; m_ptick = 0;
        end else if (m_st == 1 && t) begin
            m_ptick++;
            m_tl = CD - m_ptick / TD;
            if (m_tl == 0) begin
                m_st = 2; m_tl = RS; m_ptick = 0;
            end
        end else if (m_st == 2) begin
            m_raw += $countones(h);
            if (t) begin
                m_ptick++;
                m_tl = RS - m_ptick / TD;
                if (m_tl == 0) begin
                    m_st = 3; m_rd = 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int lvl;
        lvl = m_raw / LS > ML ? ML : m_raw / LS;
        chk("state", int'(bus.state), m_st);
        chk("time_left", int'(bus.time_left), m_tl);
        chk("hit_total", int'(bus.hit_total), m_raw > 255 ? 255 : m_raw);
        chk("level", int'(bus.level), lvl);
        chk("round_done", int'(bus.round_done), int'(m_rd));
        chk("gen_en", int'(bus.gen_en), int'(m_st == 2));
        chk("hit_en", int'(bus.hit_en), int'(m_st == 2));
        chk("mole_life", int'(bus.mole_life), LB - lvl);
        chk("spawn_period", int'(bus.spawn_period), SB - 2 * lvl);
    endtask

    task automatic cyc(input bit t, input bit s, input logic [7:0] h);
        bus.tick = t; bus.start = s; bus.hit = h;
        @(posedge clk);
        model_step(t, s, h);
        #1;
        check_model();
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_state"}, int'(bus.state), 0);
        chk({nm, "_time_left"}, int'(bus.time_left), 0);
        chk({nm, "_level"}, int'(bus.level), 0);
        chk({nm, "_hit_total"}, int'(bus.hit_total), 0);
        chk({nm, "_gen_en"}, int'(bus.gen_en), 0);
        chk({nm, "_hit_en"}, int'(bus.hit_en), 0);
        chk({nm, "_round_done"}, int'(bus.round_done), 0);
        chk({nm, "_mole_life"}, int'(bus.mole_life), LB);
        chk({nm, "_spawn_period"}, int'(bus.spawn_period), SB);
    endtask

    typedef struct {
        int         reps;
        bit         t;
        bit         s;
        logic [7:0] h;
        int         st, tl, tot, lvl, life, spn;
        bit         rd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1,  0, 1, 8'h00, 1, 3, 0,  0, 12, 20, 0};  // start -> READY
        tbl[1]  = '{1,  0, 0, 8'hFF, 1, 3, 0,  0, 12, 20, 0};  // hits in READY ignored
        tbl[2]  = '{1,  0, 1, 8'h00, 1, 3, 0,  0, 12, 20, 0};  // new start edge ignored
        tbl[3]  = '{3,  1, 0, 8'h00, 1, 3, 0,  0, 12, 20, 0};  // partial second
        tbl[4]  = '{1,  1, 0, 8'h00, 1, 2, 0,  0, 12, 20, 0};  // first second elapses
        tbl[5]  = '{7,  1, 0, 8'h00, 1, 1, 0,  0, 12, 20, 0};
        tbl[6]  = '{1,  1, 0, 8'h00, 2, 5, 0,  0, 12, 20, 0};  // 12th tick -> PLAY
        tbl[7]  = '{5,  0, 0, 8'hFF, 2, 5, 40, 4, 8,  12, 0};
        tbl[8]  = '{19, 1, 0, 8'h00, 2, 1, 40, 4, 8,  12, 0};
        tbl[9]  = '{1,  1, 0, 8'h03, 3, 0, 42, 4, 8,  12, 1};  // expiry with hits counted
        tbl[10] = '{1,  0, 0, 8'h00, 3, 0, 42, 4, 8,  12, 0};  // round_done was one clk
        tbl[11] = '{1,  0, 0, 8'hFF, 3, 0, 42, 4, 8,  12, 0};  // hits in OVER ignored

        bus.tick = 0; bus.start = 0; bus.hit = 0;
`ifdef WAM_ROUND_PAUSE_EN
        bus.pause = 0;
`endif
        model_reset();
        #2 clr = 1;
        #1 check_idle("reset");
        repeat (2) @(posedge clk);
        #1 clr = 0;
        cyc(0, 0, 8'h00);

        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < tbl[i].reps; r++)
                cyc(tbl[i].t, tbl[i].s, tbl[i].h);
            chk($sformatf("vec%0d_state", i), int'(bus.state), tbl[i].st);
            chk($sformatf("vec%0d_time_left", i), int'(bus.time_left), tbl[i].tl);
            chk($sformatf("vec%0d_hit_total", i), int'(bus.hit_total), tbl[i].tot);
            chk($sformatf("vec%0d_level", i), int'(bus.level), tbl[i].lvl);
            chk($sformatf("vec%0d_mole_life", i), int'(bus.mole_life), tbl[i].life);
            chk($sformatf("vec%0d_spawn_period", i), int'(bus.spawn_period), tbl[i].spn);
            chk($sformatf("vec%0d_round_done", i), int'(bus.round_done), int'(tbl[i].rd));
            chk($sformatf("vec%0d_gen_en", i), int'(bus.gen_en), int'(tbl[i].st == 2));
        end

        // saturation: restart from OVER, then 40 clks of all-hole hits
        cyc(0, 1, 8'h00);
        chk("restart_time_left", int'(bus.time_left), 3);
        chk("restart_hit_total", int'(bus.hit_total), 0);
        repeat (12) cyc(1, 0, 8'h00);
        repeat (40) cyc(0, 0, 8'hFF);
        chk("sat_hit_total", int'(bus.hit_total), 255);
        chk("sat_level", int'(bus.level), 7);
        chk("sat_mole_life", int'(bus.mole_life), 5);
        chk("sat_spawn_period", int'(bus.spawn_period), 6);

        // asynchronous clear in the middle of PLAY, away from any clock edge
        #3 clr = 1;
        #1 check_idle("async_clr");
        model_reset();
        @(posedge clk);
        #1 clr = 0;
        cyc(0, 1, 8'h00);
        chk("post_clr_state", int'(bus.state), 1);
        chk("post_clr_time_left", int'(bus.time_left), 3);

        // random traffic against the model
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                8'($urandom) & 8'($urandom) & 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
